// File: rtl/iq_symbol_pair_former.sv
// Decimates a complex sample stream to one sample per symbol and emits each
// consecutive symbol pair {previous, current} through a 2-entry output FIFO.
module iq_symbol_pair_former #(
  parameter int C_S00_AXIS_TDATA_WIDTH = 32,
  parameter int C_M00_AXIS_TDATA_WIDTH = 64,
  parameter int SAMPLES_PER_SYMBOL     = 8,
  parameter int SAMPLE_OFFSET          = 3
) (
  input  logic                                  s00_axis_aclk,
  input  logic                                  s00_axis_aresetn,
  input  logic                                  s00_axis_tvalid,
  input  logic                                  s00_axis_tlast,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
  input  logic [(C_S00_AXIS_TDATA_WIDTH/8)-1:0] s00_axis_tstrb,
  output logic                                  s00_axis_tready,
  input  logic                                  m00_axis_tready,
  output logic                                  m00_axis_tvalid,
  output logic                                  m00_axis_tlast,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
  output logic [(C_M00_AXIS_TDATA_WIDTH/8)-1:0] m00_axis_tstrb,
  output logic                                  frame_trunc,
  output logic [15:0]                           pair_count
);

  localparam int CNT_W = (SAMPLES_PER_SYMBOL > 2) ? $clog2(SAMPLES_PER_SYMBOL) : 1;
  localparam int ENT_W = C_M00_AXIS_TDATA_WIDTH + 1;
  localparam logic [CNT_W-1:0] L_OFFSET = CNT_W'(SAMPLE_OFFSET);
  localparam logic [CNT_W-1:0] L_LAST   = CNT_W'(SAMPLES_PER_SYMBOL - 1);

  logic                              r_rstn_q;
  logic [CNT_W-1:0]                  r_sps_cnt;
  logic                              r_have_prev;
  logic [C_S00_AXIS_TDATA_WIDTH-1:0] r_prev;
  logic                              r_frame_trunc;
  logic [15:0]                       r_pair_count;
  logic                              r_wr_ptr;
  logic                              r_rd_ptr;
  logic [1:0]                        r_count;

  logic             w_s_tready;
  logic             w_accept;
  logic             w_sym_beat;
  logic             w_push;
  logic             w_pop;
  logic             w_valid;
  logic [ENT_W-1:0] w_new_entry;
  logic [ENT_W-1:0] w_head;
  logic [ENT_W-1:0] w_entry [2];
  logic             w_unused_tstrb;

  assign w_unused_tstrb = ^s00_axis_tstrb;

  // Input readiness depends only on registered state, never on m00_axis_tready.
  assign w_s_tready  = r_rstn_q && (r_count != 2'd2);
  assign w_accept    = s00_axis_tvalid && w_s_tready;
  assign w_sym_beat  = (r_sps_cnt == L_OFFSET);
  assign w_push      = w_accept && w_sym_beat && r_have_prev;
  assign w_valid     = (r_count != 2'd0);
  assign w_pop       = w_valid && m00_axis_tready;
  assign w_new_entry = {r_prev, s00_axis_tdata, s00_axis_tlast};

  always_ff @(posedge s00_axis_aclk) begin
    r_rstn_q <= s00_axis_aresetn;
  end

  always_ff @(posedge s00_axis_aclk) begin
    if (!s00_axis_aresetn) begin
      r_sps_cnt     <= '0;
      r_have_prev   <= 1'b0;
      r_prev        <= '0;
      r_frame_trunc <= 1'b0;
      r_pair_count  <= '0;
    end else begin
      r_frame_trunc <= w_accept && s00_axis_tlast && !w_sym_beat;
      if (w_accept) begin
        // A frame end restarts symbol timing so no pair spans two frames.
        if (s00_axis_tlast) begin
          r_sps_cnt   <= '0;
          r_have_prev <= 1'b0;
        end else begin
          r_sps_cnt <= (r_sps_cnt == L_LAST) ? '0 : r_sps_cnt + 1'b1;
          if (w_sym_beat) begin
            r_have_prev <= 1'b1;
          end
        end
        if (w_sym_beat) begin
          r_prev <= s00_axis_tdata;
        end
      end
      if (w_push) begin
        r_pair_count <= r_pair_count + 16'd1;
      end
    end
  end

  always_ff @(posedge s00_axis_aclk) begin
    if (!s00_axis_aresetn) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_entry
    logic [ENT_W-1:0] r_entry;

    always_ff @(posedge s00_axis_aclk) begin
      if (!s00_axis_aresetn) begin
        r_entry <= '0;
      end else if (w_push && (r_wr_ptr == 1'(gi))) begin
        r_entry <= w_new_entry;
      end
    end

    assign w_entry[gi] = r_entry;
  end

  assign w_head = w_entry[r_rd_ptr];

  assign s00_axis_tready = w_s_tready;
  assign m00_axis_tvalid = w_valid;
  assign m00_axis_tdata  = w_valid ? w_head[ENT_W-1:1] : '0;
  assign m00_axis_tlast  = w_valid && w_head[0];
  assign m00_axis_tstrb  = w_valid ? '1 : '0;
  assign frame_trunc     = r_frame_trunc;
  assign pair_count      = r_pair_count;

endmodule
